// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the native memory bus: core (port 0) and debug/DMA (port 1), round-robin.
// Latency: one arbitration cycle from mx_valid to mem_valid; request/response paths are combinational once granted.
// Backpressure: grant held until mem_ready, master drop, or watchdog timeout; the losing port sees ready=0.
module mem_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int          CNT_W          = 7
) (
  input  logic        clk,
  input  logic        resetn,
  // port 0: minrv32 core
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  // port 1: debug / DMA master
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  // shared memory bus
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  // Watchdog value seen on the last stalled cycle before forced completion.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_wdog;
  logic             r_bus_timeout;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_mem_valid;
  logic             w_done;
  logic             w_timeout_hit;
  logic             w_complete;
  logic [31:0]      w_resp_rdata;

  assign w_gnt0 = (r_state == ST_GNT0);
  assign w_gnt1 = (r_state == ST_GNT1);

  // Request path: forward the granted port's fields, zeros when nobody owns the bus.
  always_comb begin
    w_mem_valid = 1'b0;
    mem_instr   = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_wstrb   = 4'h0;
    if (w_gnt0) begin
      w_mem_valid = m0_valid;
      mem_instr   = m0_instr;
      mem_addr    = m0_addr;
      mem_wdata   = m0_wdata;
      mem_wstrb   = m0_wstrb;
    end else if (w_gnt1) begin
      w_mem_valid = m1_valid;
      mem_addr    = m1_addr;
      mem_wdata   = m1_wdata;
      mem_wstrb   = m1_wstrb;
    end
  end

  assign mem_valid = w_mem_valid;

  // A real mem_ready on the last watchdog cycle takes precedence over the forced error.
  assign w_done        = w_mem_valid && mem_ready;
  assign w_timeout_hit = w_mem_valid && !mem_ready && (r_wdog == WDOG_LAST);
  assign w_complete    = w_done || w_timeout_hit;
  assign w_resp_rdata  = w_timeout_hit ? ERR_RDATA : mem_rdata;

  // Response path: only the granted port sees ready/rdata.
  always_comb begin
    m0_ready = 1'b0;
    m0_rdata = 32'h0;
    m1_ready = 1'b0;
    m1_rdata = 32'h0;
    if (w_gnt0) begin
      m0_ready = w_complete;
      m0_rdata = w_resp_rdata;
    end else if (w_gnt1) begin
      m1_ready = w_complete;
      m1_rdata = w_resp_rdata;
    end
  end

  assign bus_timeout = r_bus_timeout;

  // Arbitration FSM, grant history, watchdog and sticky timeout flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= 1'b1;
      r_wdog        <= '0;
      r_bus_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          if (m0_valid && m1_valid) begin
            // Tie goes to the port that did not win last time.
            if (r_last_grant) begin
              r_state      <= ST_GNT0;
              r_last_grant <= 1'b0;
            end else begin
              r_state      <= ST_GNT1;
              r_last_grant <= 1'b1;
            end
          end else if (m0_valid) begin
            r_state      <= ST_GNT0;
            r_last_grant <= 1'b0;
          end else if (m1_valid) begin
            r_state      <= ST_GNT1;
            r_last_grant <= 1'b1;
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (!w_mem_valid) begin
            // Master withdrew its request: release the bus silently.
            r_state <= ST_IDLE;
            r_wdog  <= '0;
          end else if (w_complete) begin
            r_state <= ST_IDLE;
            r_wdog  <= '0;
            if (w_timeout_hit) begin
              r_bus_timeout <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of ownership, fairness and the watchdog.
// Inputs are driven 1 ns after the rising edge; outputs are compared on the falling edge.
module tb_mem_bus_arbiter;

  localparam int          TMO = 64;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m0_instr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wstrb = '0;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m1_valid = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wstrb = '0;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR), .CNT_W(7)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    step();
    step();
    resetn = 1'b1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // owner: -1 nobody, else the port holding the bus. winner_prev: port granted most recently.
  int          owner       = -1;
  int          winner_prev = 1;
  int          stalled     = 0;
  bit          sticky      = 1'b0;
  bit          prev_hold   = 1'b0;
  logic [31:0] prev_addr   = '0;

  logic        e_valid, e_instr, e_to, e_rdy;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_wstrb;

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
      chk("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
      chk("rst_bus_timeout", {31'b0, bus_timeout}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      owner = -1; winner_prev = 1; stalled = 0; sticky = 1'b0; prev_hold = 1'b0;
    end else begin
      e_valid = (owner == 0) ? m0_valid : (owner == 1) ? m1_valid : 1'b0;
      e_instr = (owner == 0) ? m0_instr : 1'b0;
      e_addr  = (owner == 0) ? m0_addr  : (owner == 1) ? m1_addr  : 32'h0;
      e_wdata = (owner == 0) ? m0_wdata : (owner == 1) ? m1_wdata : 32'h0;
      e_wstrb = (owner == 0) ? m0_wstrb : (owner == 1) ? m1_wstrb : 4'h0;
      e_to    = e_valid && !mem_ready && (stalled == TMO - 1);
      e_rdy   = e_valid && (mem_ready || e_to);
      e_rdata = e_to ? ERR : mem_rdata;

      chk("mem_valid", {31'b0, mem_valid}, {31'b0, e_valid});
      chk("mem_instr", {31'b0, mem_instr}, {31'b0, e_instr});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_wstrb});
      chk("m0_ready", {31'b0, m0_ready}, {31'b0, (owner == 0) && e_rdy});
      chk("m1_ready", {31'b0, m1_ready}, {31'b0, (owner == 1) && e_rdy});
      chk("m0_rdata", m0_rdata, (owner == 0) ? e_rdata : 32'h0);
      chk("m1_rdata", m1_rdata, (owner == 1) ? e_rdata : 32'h0);
      chk("bus_timeout", {31'b0, bus_timeout}, {31'b0, sticky});
      chk("one_ready", {31'b0, m0_ready & m1_ready}, 32'd0);
      if (prev_hold && mem_valid) chk("addr_stable", mem_addr, prev_addr);
      prev_hold = mem_valid && !mem_ready;
      prev_addr = mem_addr;

      // advance the model to the state after the coming rising edge
      if (owner < 0) begin
        if (m0_valid && m1_valid) owner = 1 - winner_prev;
        else if (m0_valid)        owner = 0;
        else if (m1_valid)        owner = 1;
        if (owner >= 0) winner_prev = owner;
        stalled = 0;
      end else if (!e_valid || e_rdy) begin
        if (e_to) sticky = 1'b1;
        owner   = -1;
        stalled = 0;
      end else begin
        stalled++;
      end
    end
  end

  // ---------------- stimulus and directed checks ----------------
  int ord[$];
  int n;
  bit seen;
  bit pend0, pend1, r0, r1;
  int dead;

  initial begin
    // T1: single read, memory answers 3 cycles after mem_valid
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    #1 chk("t1_arb_bubble", {31'b0, mem_valid}, 32'd0);
    step();
    chk("t1_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    step();
    step();
    step();
    chk("t1_no_early_ready", {31'b0, m0_ready}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1 chk("t1_m0_ready", {31'b0, m0_ready}, 32'd1);
    chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
    step();
    idle_inputs();
    #1 chk("t1_ready_one_cycle", {31'b0, m0_ready}, 32'd0);

    // T2: both ports held from reset; service must alternate starting with port 0
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h10;
    m1_valid = 1'b1; m1_addr = 32'h20;
    mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    ord.delete();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m0_ready) ord.push_back(0);
      if (m1_ready) ord.push_back(1);
      step();
    end
    chk("t2_count", {31'b0, ord.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < ord.size(); i++) chk("t2_order", ord[i], i % 2);
    idle_inputs();

    // T3: write to a dead slave times out after exactly TMO cycles of mem_valid
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h200; m1_wdata = 32'hA5A5_0001; m1_wstrb = 4'hF;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (mem_valid) n++;
      if (m1_ready) begin
        seen = 1'b1;
        chk("t3_err_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("t3_flag_not_yet", {31'b0, bus_timeout}, 32'd0);
      end
    end
    chk("t3_ready_seen", {31'b0, seen}, 32'd1);
    chk("t3_cycles", n, 64);
    step();
    m1_valid = 1'b0;
    #1 chk("t3_sticky", {31'b0, bus_timeout}, 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("t3_sticky_holds", {31'b0, bus_timeout}, 32'd1);

    // T4: memory answers on the final watchdog cycle -> real data, no error
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h300;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (mem_valid) n++;
      if (n == TMO) begin
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        seen = 1'b1;
        chk("t4_ready", {31'b0, m0_ready}, 32'd1);
        chk("t4_rdata", m0_rdata, 32'hCAFE_F00D);
      end
    end
    chk("t4_reached", {31'b0, seen}, 32'd1);
    step();
    idle_inputs();
    #1 chk("t4_no_timeout", {31'b0, bus_timeout}, 32'd0);

    // T5: asynchronous reset in the middle of a granted transaction
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h400;
    step();
    chk("t5_granted", {31'b0, mem_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk("t5_async_drop", {31'b0, mem_valid}, 32'd0);
    chk("t5_no_ready", {31'b0, m0_ready}, 32'd0);
    step();
    step();
    resetn = 1'b1;
    #1 chk("t5_rearb_bubble", {31'b0, mem_valid}, 32'd0);
    step();
    chk("t5_regrant", {31'b0, mem_valid}, 32'd1);
    chk("t5_regrant_addr", mem_addr, 32'h400);
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1 chk("t5_complete", {31'b0, m0_ready}, 32'd1);
    step();
    idle_inputs();

    // Random traffic: independent masters, bursty slave with dead stretches, rare request drops
    do_reset();
    pend0 = 1'b0; pend1 = 1'b0; dead = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      r0 = m0_ready;
      r1 = m1_ready;
      step();
      if (pend0 && r0) pend0 = 1'b0;
      if (pend1 && r1) pend1 = 1'b0;
      if (pend0 && $urandom_range(0, 99) < 2) begin
        pend0 = 1'b0;
      end else if (!pend0 && !(m0_valid && !r0) && $urandom_range(0, 99) < 40) begin
        pend0 = 1'b1;
        m0_addr  = $urandom;
        m0_wdata = $urandom;
        m0_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        m0_instr = 1'($urandom);
      end
      if (pend1 && $urandom_range(0, 99) < 2) begin
        pend1 = 1'b0;
      end else if (!pend1 && !(m1_valid && !r1) && $urandom_range(0, 99) < 40) begin
        pend1 = 1'b1;
        m1_addr  = $urandom;
        m1_wdata = $urandom;
        m1_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      end
      m0_valid = pend0;
      m1_valid = pend1;
      if (dead > 0) dead--;
      else if ($urandom_range(0, 399) == 0) dead = 100;
      mem_ready = (dead == 0) && ($urandom_range(0, 99) < 35);
      mem_rdata = $urandom;
    end
    idle_inputs();
    step();
    step();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
